bit_serializer: RTL and testbench
=================================

// Module: bit_serializer
//
// PURPOSE
//  Parallel-to-serial front end for the serial sequence detector.
//  - Accepts W-bit words over a valid/ready handshake.
//  - Emits each word one bit per cycle on out/out_vld; out drives the detector's serial input.
//  - A one-entry pending buffer lets back-to-back words stream with no idle bit between them.
//  - Synchronous flush abandons all buffered data.
//
// PARAMETERS
//  W          8     word width in bits, >= 2
//  MSB_FIRST  1     1: bit W-1 sent first; 0: bit 0 sent first
//  IDLE_BIT   1'b0  value driven on out while out_vld=0
//
// PORTS
//  clk        in   1  clock, all flops rising edge
//  rst_n      in   1  asynchronous active-low reset
//  in_vld     in   1  upstream word valid
//  in_w       in   W  upstream word
//  in_rdy     out  1  word accepted on clk edge when in_vld & in_rdy
//  flush      in   1  synchronous abort of current and pending words
//  out        out  1  serial data bit, registered
//  out_vld    out  1  out carries a word bit this cycle, registered
//  out_sow    out  1  out is the first bit of a word (start-of-word)
//  busy       out  1  a shifting word or a pending word is held
//
// BEHAVIOUR
//  - Reset, asynchronous on rst_n low. All state clears on assertion:
//    - FSM goes to IDLE, bit count cnt = 0, pend_vld = 0.
//    - out = IDLE_BIT, out_vld = 0, out_sow = 0.
//    - in_rdy = 0 while rst_n is low.
//    - Reset mid-word drops that word; no partial bits follow.
//  - in_rdy = rst_n & ~pend_vld & ~flush.
//    - There is no combinational path from in_vld to in_rdy.
//  - States:
//    - IDLE: nothing shifting.
//    - SHIFT: shift register sr holds the current word; cnt counts 0..W-1.
//  - IDLE transitions:
//    - Accept in cycle N: load sr, go to SHIFT.
//    - The first bit appears on out with out_vld=1, out_sow=1 in cycle N+1.
//  - SHIFT transitions:
//    - Each cycle one bit is registered onto out and cnt increments.
//    - The bit is sr[W-1] then shift left when MSB_FIRST=1; sr[0] then shift right when MSB_FIRST=0.
//  - Last bit (cnt == W-1):
//    - If pend_vld, or a word is accepted this same cycle: load sr from it, cnt = 0, stay in SHIFT.
//    - Load is from the pending buffer, else directly from in_w.
//    - The next word's first bit follows in the very next cycle with out_sow = 1: zero gap.
//    - Otherwise go to IDLE; out_vld = 0 and out = IDLE_BIT from the next cycle.
//  - Accept while in SHIFT and not on the last bit: the word goes to the pending buffer, pend_vld = 1.
//    - in_rdy then drops until the buffer is consumed.
//  - Simultaneous consume and accept on the last bit with pend_vld = 1:
//    - Cannot happen, because in_rdy = 0.
//    - Steady-state throughput is therefore W bits per W cycles, with in_rdy pulsing once per word.
//  - flush takes priority over everything:
//    - Next cycle: IDLE, pend_vld = 0, out_vld = 0, out = IDLE_BIT.
//    - in_vld is ignored in the flush cycle.
//  - busy = (state == SHIFT) | pend_vld, from registers.
//  - cnt width is $clog2(W); cnt wraps only through a reload to 0.
//
// TESTING
//  - Reset, then one word 8'h9A, MSB_FIRST=1:
//    - Accepted in cycle N.
//    - out = 1,0,0,1,1,0,1,0 in cycles N+1..N+8; out_sow only at N+1.
//    - out_vld = 0 at N+9.
//  - Back-to-back words 8'h9A, 8'hFF with in_vld held high:
//    - 16 consecutive out_vld cycles with no gap.
//    - out_sow at bits 0 and 8; in_rdy low while pend_vld = 1.
//  - MSB_FIRST=0, word 8'h01:
//    - First out bit is 1, followed by seven 0s.
//  - flush asserted at bit 3 of 8'h9A with 8'h55 pending:
//    - out_vld = 0 the next cycle, busy = 0.
//    - No 8'h55 bits are ever emitted; in_rdy = 1 one cycle later.
//  - rst_n pulsed low mid-word, asynchronously between edges:
//    - out_vld = 0 and in_rdy = 0 immediately.
//    - After release, a new word 8'hA5 serializes cleanly from bit 7.
//  - Random words, random in_vld gaps, serializer feeding the detector:
//    - The detector's fail output never asserts.
//    - A scoreboard of the deserialized stream matches the accepted words.

Source files
------------

// File: rtl/bit_serializer.sv
`default_nettype none
// ============================================================================
// Module      : bit_serializer
// Description : Parallel-to-serial front end for the serial sequence detector.
//               Shifts W-bit words out one bit per cycle. A one-word pending
//               buffer lets consecutive words follow each other with no gap.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_serializer #(
    parameter int   W         = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_vld,
    input  logic [W-1:0] in_w,
    output logic         in_rdy,
    input  logic         flush,
    output logic         out,
    output logic         out_vld,
    output logic         out_sow,
    output logic         busy
);

    localparam int            CW     = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(W - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t        state;
    state_t        state_d;
    logic [W-1:0]  sr;
    logic [W-1:0]  sr_d;
    logic [W-1:0]  pend;
    logic [W-1:0]  pend_d;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_d;
    logic          pend_vld;
    logic          pend_vld_d;
    logic          out_d;
    logic          out_vld_d;
    logic          out_sow_d;

    logic          accept;
    logic          last_bit;
    logic [W-1:0]  load_word;
    logic          head_of_load;
    logic [W-1:0]  rest_of_load;
    logic          head_of_sr;
    logic [W-1:0]  rest_of_sr;

    // in_rdy depends only on registers, reset and flush; never on in_vld
    assign in_rdy   = rst_n & ~pend_vld & ~flush;
    assign accept   = in_vld & in_rdy;
    assign last_bit = (state == S_SHIFT) && (cnt == C_LAST);

    // A pending word is only ever consumed on the last bit, where in_rdy is 0
    assign load_word = pend_vld ? pend : in_w;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign head_of_load = load_word[W-1];
            assign rest_of_load = {load_word[W-2:0], 1'b0};
            assign head_of_sr   = sr[W-1];
            assign rest_of_sr   = {sr[W-2:0], 1'b0};
        end else begin : g_lsb_first
            assign head_of_load = load_word[0];
            assign rest_of_load = {1'b0, load_word[W-1:1]};
            assign head_of_sr   = sr[0];
            assign rest_of_sr   = {1'b0, sr[W-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            sr       <= '0;
            pend     <= '0;
            cnt      <= '0;
            pend_vld <= 1'b0;
            out      <= IDLE_BIT;
            out_vld  <= 1'b0;
            out_sow  <= 1'b0;
        end else begin
            state    <= state_d;
            sr       <= sr_d;
            pend     <= pend_d;
            cnt      <= cnt_d;
            pend_vld <= pend_vld_d;
            out      <= out_d;
            out_vld  <= out_vld_d;
            out_sow  <= out_sow_d;
        end
    end

    // The first bit of a loaded word goes straight onto out; sr keeps the rest
    always_comb begin
        state_d    = state;
        sr_d       = sr;
        pend_d     = pend;
        cnt_d      = cnt;
        pend_vld_d = pend_vld;
        out_d      = out;
        out_vld_d  = out_vld;
        out_sow_d  = 1'b0;

        if (flush) begin
            state_d    = S_IDLE;
            cnt_d      = '0;
            pend_vld_d = 1'b0;
            out_d      = IDLE_BIT;
            out_vld_d  = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state_d   = S_SHIFT;
                        sr_d      = rest_of_load;
                        cnt_d     = '0;
                        out_d     = head_of_load;
                        out_vld_d = 1'b1;
                        out_sow_d = 1'b1;
                    end else begin
                        out_d     = IDLE_BIT;
                        out_vld_d = 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (last_bit) begin
                        if (pend_vld || accept) begin
                            sr_d       = rest_of_load;
                            cnt_d      = '0;
                            pend_vld_d = 1'b0;
                            out_d      = head_of_load;
                            out_vld_d  = 1'b1;
                            out_sow_d  = 1'b1;
                        end else begin
                            state_d   = S_IDLE;
                            cnt_d     = '0;
                            out_d     = IDLE_BIT;
                            out_vld_d = 1'b0;
                        end
                    end else begin
                        sr_d      = rest_of_sr;
                        cnt_d     = cnt + CW'(1);
                        out_d     = head_of_sr;
                        out_vld_d = 1'b1;
                        if (accept) begin
                            pend_d     = in_w;
                            pend_vld_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d   = S_IDLE;
                    out_d     = IDLE_BIT;
                    out_vld_d = 1'b0;
                end
            endcase
        end
    end

    assign busy = (state == S_SHIFT) | pend_vld;

endmodule
`default_nettype wire

// File: tb/tb_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bit_serializer
// Description : Self-checking bench for bit_serializer; MSB-first and
//               LSB-first instances share stimulus and a bit-queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_serializer;

    localparam int W = 8;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b1;
    logic         in_vld = 1'b0;
    logic [W-1:0] in_w   = '0;
    logic         flush  = 1'b0;

    logic m_rdy, m_out, m_vld, m_sow, m_busy;
    logic l_rdy, l_out, l_vld, l_sow, l_busy;

    always #5 clk = ~clk;

    bit_serializer #(.W(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (in_vld),
        .in_w    (in_w),
        .in_rdy  (m_rdy),
        .flush   (flush),
        .out     (m_out),
        .out_vld (m_vld),
        .out_sow (m_sow),
        .busy    (m_busy)
    );

    bit_serializer #(.W(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (in_vld),
        .in_w    (in_w),
        .in_rdy  (l_rdy),
        .flush   (flush),
        .out     (l_out),
        .out_vld (l_vld),
        .out_sow (l_sow),
        .busy    (l_busy)
    );

    // Model: each accepted word appends its bits, tagged {sow, bit}, in wire order
    logic [1:0] qm[$];
    logic [1:0] ql[$];

    int vectors     = 0;
    int miscompares = 0;

    logic last_m_out, last_m_vld, last_m_sow, last_m_busy;
    logic last_l_out, last_l_vld, last_l_sow;
    logic last_rdy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_side(input string nm, input logic o, input logic v, input logic s,
                              input logic b, input bit have, input logic [1:0] front,
                              input bit pend);
        check({nm, ".out_vld"}, v, have);
        check({nm, ".out"}, o, have ? front[0] : 1'b0);
        check({nm, ".out_sow"}, s, have & front[1]);
        check({nm, ".busy"}, b, have | pend);
    endtask

    task automatic step(input logic v, input logic [W-1:0] w, input logic f);
        bit         have;
        bit         pend;
        bit         exp_rdy;
        logic [1:0] fm;
        logic [1:0] fl;
        @(negedge clk);
        have = (qm.size() > 0);
        fm   = have ? qm[0] : 2'b00;
        fl   = have ? ql[0] : 2'b00;
        pend = 1'b0;
        for (int i = 1; i < qm.size(); i++) if (qm[i][1]) pend = 1'b1;
        check_side("msb", m_out, m_vld, m_sow, m_busy, have, fm, pend);
        check_side("lsb", l_out, l_vld, l_sow, l_busy, have, fl, pend);
        last_m_out  = m_out;
        last_m_vld  = m_vld;
        last_m_sow  = m_sow;
        last_m_busy = m_busy;
        last_l_out  = l_out;
        last_l_vld  = l_vld;
        last_l_sow  = l_sow;
        if (have) begin
            void'(qm.pop_front());
            void'(ql.pop_front());
        end
        in_vld = v;
        in_w   = w;
        flush  = f;
        #1;
        exp_rdy = !f && !pend;
        check("msb.in_rdy", m_rdy, exp_rdy);
        check("lsb.in_rdy", l_rdy, exp_rdy);
        last_rdy = m_rdy;
        if (f) begin
            qm.delete();
            ql.delete();
        end else if (v && exp_rdy) begin
            for (int i = 0; i < W; i++) begin
                qm.push_back({i == 0, w[W-1-i]});
                ql.push_back({i == 0, w[i]});
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  seq;
        logic [7:0]  sows;
        logic [16:0] vb;
        logic [16:0] sb;
        logic [16:0] rb;
        int          vcnt;

        // Reset state
        #1 rst_n = 1'b0;
        #11;
        check("rst.out_vld", m_vld, 1'b0);
        check("rst.out", m_out, 1'b0);
        check("rst.out_sow", m_sow, 1'b0);
        check("rst.in_rdy", m_rdy, 1'b0);
        check("rst.busy", m_busy, 1'b0);
        check("rst.lsb_out_vld", l_vld, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single word 8'h9A
        step(1'b1, 8'h9A, 1'b0);
        seq = '0; sows = '0; vcnt = 0;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, '0, 1'b0);
            seq  = {seq[6:0], last_m_out};
            sows = {sows[6:0], last_m_sow};
            vcnt += int'(last_m_vld);
        end
        check("t1.bits", seq, 8'h9A);
        check("t1.sow", sows, 8'h80);
        check("t1.vld_cnt", vcnt, 8);
        step(1'b0, '0, 1'b0);
        check("t1.idle_after", last_m_vld, 1'b0);

        // Back-to-back 8'h9A, 8'hFF
        step(1'b1, 8'h9A, 1'b0);
        vb = '0; sb = '0; rb = '0;
        for (int j = 0; j < 17; j++) begin
            step(j == 0, (j == 0) ? 8'hFF : 8'h00, 1'b0);
            vb[j] = last_m_vld;
            sb[j] = last_m_sow;
            rb[j] = last_rdy;
        end
        check("t2.vld", vb, 17'h0FFFF);
        check("t2.sow", sb, 17'h00101);
        check("t2.rdy", rb, 17'h1FF01);

        // LSB-first 8'h01
        step(1'b1, 8'h01, 1'b0);
        seq = '0; sows = '0;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, '0, 1'b0);
            seq  = {seq[6:0], last_l_out};
            sows = {sows[6:0], last_l_sow};
        end
        check("t3.lsb_bits", seq, 8'h80);
        check("t3.lsb_sow", sows, 8'h80);
        step(1'b0, '0, 1'b0);
        check("t3.lsb_idle", last_l_vld, 1'b0);

        // Flush at bit 3 with 8'h55 pending
        step(1'b1, 8'h9A, 1'b0);
        step(1'b1, 8'h55, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        check("t4.bit3", last_m_out, 1'b1);
        check("t4.busy_before", last_m_busy, 1'b1);
        step(1'b0, '0, 1'b0);
        check("t4.vld_after", last_m_vld, 1'b0);
        check("t4.busy_after", last_m_busy, 1'b0);
        check("t4.rdy_after", last_rdy, 1'b1);
        vcnt = 0;
        for (int k = 0; k < 10; k++) begin
            step(1'b0, '0, 1'b0);
            vcnt += int'(last_m_vld);
        end
        check("t4.no_pending_bits", vcnt, 0);

        // Asynchronous reset mid-word, then 8'hA5
        step(1'b1, 8'hC3, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5.rst_vld", m_vld, 1'b0);
        check("t5.rst_rdy", m_rdy, 1'b0);
        check("t5.rst_busy", m_busy, 1'b0);
        check("t5.rst_lsb_vld", l_vld, 1'b0);
        qm.delete();
        ql.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 8'hA5, 1'b0);
        seq = '0; sows = '0;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, '0, 1'b0);
            seq  = {seq[6:0], last_m_out};
            sows = {sows[6:0], last_m_sow};
        end
        check("t5.bits", seq, 8'hA5);
        check("t5.sow", sows, 8'h80);

        // Random words, gaps and occasional flush
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 49) == 0);
        end
        for (int k = 0; k < 12; k++) step(1'b0, '0, 1'b0);
        check("t6.drained", last_m_vld, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
